// File: rtl/control_pkg.sv
// Shared encodings for the instruction sequencer: state codes, instruction
// classes, and the per-class decode helpers used by the sequencer FSM.
package control_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_EXECUTE   = 4'd3,
        ST_MEM       = 4'd4,
        ST_LATCH     = 4'd5,
        ST_WRITEBACK = 4'd6,
        ST_HALT      = 4'd7,
        ST_FAULT     = 4'd8
    } state_e;

    // Instruction classes as produced by the decoder; anything above IT_UPC is illegal.
    localparam logic [31:0] IT_R   = 32'd0;
    localparam logic [31:0] IT_I   = 32'd1;
    localparam logic [31:0] IT_S   = 32'd2;
    localparam logic [31:0] IT_B   = 32'd3;
    localparam logic [31:0] IT_U   = 32'd4;
    localparam logic [31:0] IT_L   = 32'd5;
    localparam logic [31:0] IT_J   = 32'd6;
    localparam logic [31:0] IT_JR  = 32'd7;
    localparam logic [31:0] IT_UPC = 32'd8;

    function automatic logic is_legal(input logic [31:0] it);
        return it <= IT_UPC;
    endfunction

    function automatic logic is_mem(input logic [31:0] it);
        return (it == IT_S) || (it == IT_L);
    endfunction

    function automatic logic is_writer(input logic [31:0] it);
        return is_legal(it) && (it != IT_S) && (it != IT_B);
    endfunction

    // Operand latch strobes as {a, b, pass}.
    function automatic logic [2:0] operand_mask(input logic [31:0] it);
        logic [2:0] m;
        m = 3'b000;
        case (it)
            IT_R, IT_I, IT_L: m = 3'b110;
            IT_S, IT_B:       m = 3'b111;
            IT_U, IT_JR:      m = 3'b100;
            default:          m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/seq_control_wait_timer.sv
// Memory wait-state watchdog: down-counter loaded while idle, counting cycles
// without ack during a request. MAX_WAIT of 0 never expires.
module wait_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic ack_i,
    output logic expired_o
);
    localparam int unsigned W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = W'(MAX_WAIT);
        end else if (!ack_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= W'(MAX_WAIT);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Terminal count is 1: this cycle would be the MAX_WAIT-th without ack.
    assign expired_o = (MAX_WAIT != 0) && !clear_i && !ack_i && (cnt_q == W'(1));

endmodule

// File: rtl/seq_control.sv
// Multi-cycle instruction sequencer: fetch over req/ack, decode, execute,
// optional memory stage, operand latch and write-back, with halt and fault.
//
// state     | meaning
// IDLE      | after reset, waiting to start
// FETCH     | instruction read request, IR captured on ack
// DECODE    | itype legality check
// EXECUTE   | ALU operand latch strobes
// MEM       | load/store data access
// LATCH     | write-back data capture
// WRITEBACK | register write, PC advance, retire
// HALT      | stopped at instruction boundary
// FAULT     | bus timeout or illegal itype, sticky until reset
module seq_control
    import control_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ITYPE_W  = 5,
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               halt_i,
    output logic [3:0]         stage_o,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [XLEN-1:0]    mem_addr_o,
    output logic [XLEN-1:0]    mem_wdata_o,
    input  logic [XLEN-1:0]    mem_rdata_i,
    input  logic               mem_ack_i,
    input  logic [XLEN-1:0]    pc_i,
    input  logic [XLEN-1:0]    alu_res_i,
    input  logic [XLEN-1:0]    store_data_i,
    output logic [XLEN-1:0]    ir_o,
    input  logic [ITYPE_W-1:0] itype_i,
    output logic               readin_a_o,
    output logic               readin_b_o,
    output logic               readin_pass_o,
    output logic [XLEN-1:0]    load_data_o,
    output logic               wd_q_readin_o,
    output logic               wd_q_o,
    output logic               pc_readin_o,
    output logic               fault_o,
    output logic [CNT_W-1:0]   retired_o
);
    state_e            state_q, state_d;
    logic [XLEN-1:0]   ir_q, ir_d;
    logic [XLEN-1:0]   load_data_q, load_data_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic [31:0]       it;
    logic              timer_clear;
    logic              timer_expired;

    assign it          = 32'(itype_i);
    assign timer_clear = (state_q != ST_FETCH) && (state_q != ST_MEM);

    wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (timer_clear),
        .ack_i     (mem_ack_i),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        load_data_d   = load_data_q;
        retired_d     = retired_q;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        readin_a_o    = 1'b0;
        readin_b_o    = 1'b0;
        readin_pass_o = 1'b0;
        wd_q_readin_o = 1'b0;
        wd_q_o        = 1'b0;
        pc_readin_o   = 1'b0;
        fault_o       = 1'b0;
        case (state_q)
            ST_IDLE: state_d = halt_i ? ST_HALT : ST_FETCH;
            ST_FETCH: begin
                mem_req_o  = 1'b1;
                mem_addr_o = pc_i;
                if (mem_ack_i) begin
                    ir_d    = mem_rdata_i;
                    state_d = ST_DECODE;
                end else if (timer_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DECODE: state_d = is_legal(it) ? ST_EXECUTE : ST_FAULT;
            ST_EXECUTE: begin
                {readin_a_o, readin_b_o, readin_pass_o} = operand_mask(it);
                state_d = is_mem(it) ? ST_MEM : ST_LATCH;
            end
            ST_MEM: begin
                mem_req_o   = 1'b1;
                mem_we_o    = (it == IT_S);
                mem_addr_o  = alu_res_i;
                mem_wdata_o = store_data_i;
                if (mem_ack_i) begin
                    if (it == IT_L) begin
                        load_data_d = mem_rdata_i;
                    end
                    state_d = ST_LATCH;
                end else if (timer_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_LATCH: begin
                wd_q_readin_o = is_writer(it);
                state_d       = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                wd_q_o      = is_writer(it);
                pc_readin_o = 1'b1;
                retired_d   = retired_q + CNT_W'(1);
                state_d     = halt_i ? ST_HALT : ST_FETCH;
            end
            ST_HALT:  state_d = halt_i ? ST_HALT : ST_FETCH;
            ST_FAULT: fault_o = 1'b1;
            default:  state_d = ST_FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ir_q        <= '0;
            load_data_q <= '0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            load_data_q <= load_data_d;
            retired_q   <= retired_d;
        end
    end

    assign stage_o     = state_q;
    assign ir_o        = ir_q;
    assign load_data_o = load_data_q;
    assign retired_o   = retired_q;

endmodule

// File: tb/tb_seq_control.sv
// Bench for seq_control: a reactive memory responder drives the handshake and
// per-cycle outputs are compared with a stage trace built from the class tables.
module tb_seq_control;
    localparam int unsigned XLEN = 32;
    localparam int unsigned ITW  = 5;
    localparam int unsigned MW   = 4;
    localparam int unsigned CW   = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            halt_i = 1'b0;
    logic [3:0]      stage_o;
    logic            mem_req_o, mem_we_o;
    logic [XLEN-1:0] mem_addr_o, mem_wdata_o;
    logic [XLEN-1:0] mem_rdata_i = '0;
    logic            mem_ack_i = 1'b0;
    logic [XLEN-1:0] pc_i = '0, alu_res_i = '0, store_data_i = '0;
    logic [XLEN-1:0] ir_o, load_data_o;
    logic [ITW-1:0]  itype_i = '0;
    logic            readin_a_o, readin_b_o, readin_pass_o;
    logic            wd_q_readin_o, wd_q_o, pc_readin_o, fault_o;
    logic [CW-1:0]   retired_o;

    seq_control #(.XLEN(XLEN), .ITYPE_W(ITW), .MAX_WAIT(MW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .halt_i(halt_i), .stage_o(stage_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .pc_i(pc_i), .alu_res_i(alu_res_i), .store_data_i(store_data_i), .ir_o(ir_o),
        .itype_i(itype_i), .readin_a_o(readin_a_o), .readin_b_o(readin_b_o),
        .readin_pass_o(readin_pass_o), .load_data_o(load_data_o),
        .wd_q_readin_o(wd_q_readin_o), .wd_q_o(wd_q_o), .pc_readin_o(pc_readin_o),
        .fault_o(fault_o), .retired_o(retired_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  stage;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        a, b, p, wdr, wd, pcr, fault;
    } obs_t;

    int tests = 0;
    int fails = 0;
    obs_t exp_q[$];
    obs_t got_q[$];
    logic [31:0] exp_ir = '0, exp_ld = '0;
    logic [CW-1:0] exp_ret = '0;

    // Class order: R I S B U L J JR UPC
    logic [2:0] mask_t   [0:8] = '{3'b110, 3'b110, 3'b111, 3'b111, 3'b100, 3'b110, 3'b000, 3'b100, 3'b000};
    logic       writer_t [0:8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    function automatic obs_t sample();
        obs_t o;
        o.stage = stage_o;     o.req = mem_req_o;      o.we = mem_we_o;
        o.addr = mem_addr_o;   o.wdata = mem_wdata_o;
        o.a = readin_a_o;      o.b = readin_b_o;       o.p = readin_pass_o;
        o.wdr = wd_q_readin_o; o.wd = wd_q_o;          o.pcr = pc_readin_o;
        o.fault = fault_o;
        return o;
    endfunction

    // Expected cycle-by-cycle outputs for one instruction with wf/wm wait states.
    function automatic void build_exp(int it, int wf, int wm);
        obs_t o;
        exp_q.delete();
        for (int i = 0; i <= wf; i++) begin
            o = '0; o.stage = 4'd1; o.req = 1'b1; o.addr = pc_i;
            exp_q.push_back(o);
        end
        o = '0; o.stage = 4'd2;
        exp_q.push_back(o);
        o = '0; o.stage = 4'd3; {o.a, o.b, o.p} = mask_t[it];
        exp_q.push_back(o);
        if (it == 2 || it == 5) begin
            for (int i = 0; i <= wm; i++) begin
                o = '0; o.stage = 4'd4; o.req = 1'b1; o.we = (it == 2);
                o.addr = alu_res_i; o.wdata = store_data_i;
                exp_q.push_back(o);
            end
        end
        o = '0; o.stage = 4'd5; o.wdr = writer_t[it];
        exp_q.push_back(o);
        o = '0; o.stage = 4'd6; o.wd = writer_t[it]; o.pcr = 1'b1;
        exp_q.push_back(o);
    endfunction

    // Memory responder: acks after wf (fetch) / wm (data) wait cycles, random ack elsewhere.
    task automatic drive(input int ncyc, input int wf, input int wm,
                         input logic [31:0] rd_f, input logic [31:0] rd_m);
        int nf = 0;
        int nm = 0;
        got_q.delete();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (stage_o == 4'd1) begin
                mem_ack_i = (nf == wf); nf++;
                mem_rdata_i = mem_ack_i ? rd_f : $urandom;
            end else if (stage_o == 4'd4) begin
                mem_ack_i = (nm == wm); nm++;
                mem_rdata_i = mem_ack_i ? rd_m : $urandom;
            end else begin
                mem_ack_i = 1'($urandom_range(0, 1));
                mem_rdata_i = $urandom;
            end
            #1 got_q.push_back(sample());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; halt_i = 1'b0; mem_ack_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_ir = '0; exp_ld = '0; exp_ret = '0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests++; if (sample() !== obs_t'('0)) begin fails++; $display("FAIL reset_outputs got %h exp 0", sample()); end
        tests++; if (ir_o !== '0) begin fails++; $display("FAIL reset_ir got %h exp 0", ir_o); end
        tests++; if (load_data_o !== '0) begin fails++; $display("FAIL reset_ld got %h exp 0", load_data_o); end
        tests++; if (retired_o !== '0) begin fails++; $display("FAIL reset_retired got %0d exp 0", retired_o); end
    endtask

    task automatic test_rtype();
        logic [31:0] rf = $urandom;
        itype_i = 5'd0; pc_i = $urandom; alu_res_i = $urandom; store_data_i = $urandom;
        build_exp(0, 0, 0);
        drive(exp_q.size(), 0, 0, rf, 32'h0);
        for (int i = 0; i < exp_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rtype cyc%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        exp_ir = rf; exp_ret = exp_ret + 1'b1;
        @(posedge clk); #1;
        tests++; if (stage_o !== 4'd1) begin fails++; $display("FAIL rtype_next got %0d exp 1", stage_o); end
        tests++; if (retired_o !== exp_ret) begin fails++; $display("FAIL rtype_retired got %0d exp %0d", retired_o, exp_ret); end
        tests++; if (ir_o !== exp_ir) begin fails++; $display("FAIL rtype_ir got %h exp %h", ir_o, exp_ir); end
    endtask

    task automatic test_load();
        itype_i = 5'd5; pc_i = $urandom; alu_res_i = $urandom; store_data_i = $urandom;
        build_exp(5, 0, 3);
        drive(exp_q.size(), 0, 3, 32'h1234_5678, 32'hDEAD_BEEF);
        tests++; if (exp_q.size() != 9) begin fails++; $display("FAIL load_len got %0d exp 9", exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL load cyc%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        exp_ir = 32'h1234_5678; exp_ld = 32'hDEAD_BEEF; exp_ret = exp_ret + 1'b1;
        @(posedge clk); #1;
        tests++; if (stage_o !== 4'd1) begin fails++; $display("FAIL load_next got %0d exp 1", stage_o); end
        tests++; if (load_data_o !== exp_ld) begin fails++; $display("FAIL load_data got %h exp %h", load_data_o, exp_ld); end
        tests++; if (retired_o !== exp_ret) begin fails++; $display("FAIL load_retired got %0d exp %0d", retired_o, exp_ret); end
    endtask

    task automatic test_store();
        logic [31:0] rf = $urandom;
        itype_i = 5'd2; pc_i = $urandom; alu_res_i = 32'h100; store_data_i = 32'h55;
        build_exp(2, 1, 0);
        drive(exp_q.size(), 1, 0, rf, $urandom);
        for (int i = 0; i < exp_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL store cyc%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        exp_ir = rf; exp_ret = exp_ret + 1'b1;
        @(posedge clk); #1;
        tests++; if (load_data_o !== exp_ld) begin fails++; $display("FAIL store_ld got %h exp %h", load_data_o, exp_ld); end
        tests++; if (retired_o !== exp_ret) begin fails++; $display("FAIL store_retired got %0d exp %0d", retired_o, exp_ret); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            int it = $urandom_range(0, 8);
            int wf = $urandom_range(0, MW - 1);
            int wm = $urandom_range(0, MW - 1);
            logic [31:0] rf = $urandom;
            logic [31:0] rm = $urandom;
            itype_i = 5'(it); pc_i = $urandom; alu_res_i = $urandom; store_data_i = $urandom;
            build_exp(it, wf, wm);
            drive(exp_q.size(), wf, wm, rf, rm);
            for (int i = 0; i < exp_q.size(); i++) begin
                tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand%0d it%0d cyc%0d got %h exp %h", n, it, i, got_q[i], exp_q[i]); end
            end
            exp_ir = rf; exp_ret = exp_ret + 1'b1;
            if (it == 5) exp_ld = rm;
            @(posedge clk); #1;
            tests++; if ({stage_o, ir_o, load_data_o, retired_o} !== {4'd1, exp_ir, exp_ld, exp_ret}) begin
                fails++; $display("FAIL rand%0d_after got st%0d ir%h ld%h ret%0d exp st1 ir%h ld%h ret%0d",
                                  n, stage_o, ir_o, load_data_o, retired_o, exp_ir, exp_ld, exp_ret);
            end
        end
    endtask

    task automatic test_halt();
        obs_t h = '0;
        h.stage = 4'd7;
        halt_i = 1'b1; itype_i = 5'd1; pc_i = $urandom; alu_res_i = $urandom; store_data_i = $urandom;
        build_exp(1, 0, 0);
        drive(exp_q.size(), 0, 0, $urandom, 32'h0);
        for (int i = 0; i < exp_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL halt_instr cyc%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        exp_ret = exp_ret + 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); mem_ack_i = 1'($urandom_range(0, 1)); #1;
            tests++; if (sample() !== h) begin fails++; $display("FAIL halt_hold cyc%0d got %h exp %h", i, sample(), h); end
        end
        tests++; if (retired_o !== exp_ret) begin fails++; $display("FAIL halt_retired got %0d exp %0d", retired_o, exp_ret); end
        halt_i = 1'b0;
        @(posedge clk); #1;
        tests++; if (stage_o !== 4'd1) begin fails++; $display("FAIL halt_release got %0d exp 1", stage_o); end
    endtask

    task automatic test_illegal();
        obs_t o;
        logic [31:0] rf = $urandom;
        do_reset();
        itype_i = 5'($urandom_range(9, 31)); pc_i = $urandom;
        drive(6, 0, 0, rf, 32'h0);
        for (int i = 0; i < 6; i++) begin
            o = '0;
            if (i == 0) begin o.stage = 4'd1; o.req = 1'b1; o.addr = pc_i; end
            else if (i == 1) o.stage = 4'd2;
            else begin o.stage = 4'd8; o.fault = 1'b1; end
            tests++; if (got_q[i] !== o) begin fails++; $display("FAIL illegal cyc%0d got %h exp %h", i, got_q[i], o); end
        end
        tests++; if (ir_o !== rf) begin fails++; $display("FAIL illegal_ir got %h exp %h", ir_o, rf); end
        do_reset(); #1;
        tests++; if ({stage_o, fault_o} !== 5'd0) begin fails++; $display("FAIL illegal_reset got st%0d f%0d exp st0 f0", stage_o, fault_o); end
    endtask

    task automatic test_timeout();
        obs_t o;
        pc_i = $urandom;
        drive(7, 99, 0, 32'h0, 32'h0);
        for (int i = 0; i < 7; i++) begin
            o = '0;
            if (i < int'(MW)) begin o.stage = 4'd1; o.req = 1'b1; o.addr = pc_i; end
            else begin o.stage = 4'd8; o.fault = 1'b1; end
            tests++; if (got_q[i] !== o) begin fails++; $display("FAIL tmo_fetch cyc%0d got %h exp %h", i, got_q[i], o); end
        end
        do_reset(); #1;
        tests++; if ({stage_o, fault_o} !== 5'd0) begin fails++; $display("FAIL tmo_reset got st%0d f%0d exp st0 f0", stage_o, fault_o); end
        itype_i = 5'd2; pc_i = $urandom; alu_res_i = $urandom; store_data_i = $urandom;
        build_exp(2, 0, MW - 1);
        drive(10, 0, 99, $urandom, 32'h0);
        o = '0; o.stage = 4'd8; o.fault = 1'b1;
        for (int i = 0; i < 10; i++) begin
            obs_t e = (i < 3 + int'(MW)) ? exp_q[i] : o;
            tests++; if (got_q[i] !== e) begin fails++; $display("FAIL tmo_mem cyc%0d got %h exp %h", i, got_q[i], e); end
        end
        do_reset(); #1;
    endtask

    task automatic test_reset_mid_mem();
        itype_i = 5'd5; pc_i = $urandom; alu_res_i = $urandom; store_data_i = $urandom;
        drive(5, 0, 99, 32'hA5A5_0001, 32'h0);
        tests++; if ({got_q[4].stage, got_q[4].req} !== {4'd4, 1'b1}) begin
            fails++; $display("FAIL midmem_pre got st%0d req%0d exp st4 req1", got_q[4].stage, got_q[4].req);
        end
        reset = 1'b1; mem_ack_i = 1'b0;
        @(posedge clk); #1;
        tests++; if (sample() !== obs_t'('0)) begin fails++; $display("FAIL midmem_outputs got %h exp 0", sample()); end
        tests++; if ({ir_o, load_data_o, retired_o} !== '0) begin
            fails++; $display("FAIL midmem_regs got ir%h ld%h ret%0d exp 0", ir_o, load_data_o, retired_o);
        end
        @(negedge clk); reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rtype();
        test_load();
        test_store();
        test_random();
        test_halt();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_control.md
Name: seq_control

Overview:
- Parametrised multi-cycle sequencer for the Pillar core. It replaces the fixed five-count stage controller with an explicit state machine.
- It fetches instructions over a req/ack memory handshake with wait states and latches the IR synchronously.
- It runs the memory stage only for loads and stores, and supports halt and a bus-timeout fault.
- It sits between the RAM port, the fetch/PC unit, the decoder (itype), the ALU operand latches and the write-back register.

Parameters:
XLEN, 32, data/address width
ITYPE_W, 5, width of itype code
MAX_WAIT, 15, cycles allowed without mem_ack_i before FAULT; 0 disables timeout
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
halt_i  in  1  request to stop at the next instruction boundary
stage_o  out  4  current state code
mem_req_o  out  1  memory request, held until ack
mem_we_o  out  1  write enable; valid with mem_req_o
mem_addr_o  out  XLEN  memory address
mem_wdata_o  out  XLEN  store data
mem_rdata_i  in  XLEN  memory read data, valid with ack
mem_ack_i  in  1  memory completes the request this cycle
pc_i  in  XLEN  current PC
alu_res_i  in  XLEN  effective address for load/store
store_data_i  in  XLEN  rs2 value for stores
ir_o  out  XLEN  instruction register
itype_i  in  ITYPE_W  decoded instruction class of ir_o
readin_a_o / readin_b_o / readin_pass_o  out  1 each  ALU operand latch strobes
load_data_o  out  XLEN  captured load data
wd_q_readin_o  out  1  write-back data capture strobe
wd_q_o  out  1  register-file write strobe
pc_readin_o  out  1  PC advance strobe
fault_o  out  1  sticky bus-timeout or illegal-itype fault
retired_o  out  CNT_W  count of instructions retired

Behaviour:
- Reset (sampled at posedge clk):
  - state=IDLE(0); ir_o=0, load_data_o=0, retired_o=0, fault_o=0.
  - All strobes and mem_* outputs are 0.
  - Reset overrides every other input, including mid-request: mem_req_o is low in the cycle after reset is sampled.
- State codes: IDLE 0, FETCH 1, DECODE 2, EXECUTE 3, MEM 4, LATCH 5, WRITEBACK 6, HALT 7, FAULT 8. All strobes decode from the registered state only, so each is high for exactly one cycle per state visit.
- IDLE: next state is HALT if halt_i, else FETCH.
- FETCH:
  - Drives mem_req_o=1, mem_we_o=0, mem_addr_o=pc_i.
  - On mem_ack_i, ir_o<=mem_rdata_i and next state is DECODE.
  - Ack in the first FETCH cycle is legal (zero wait).
- DECODE: one cycle. If itype_i is not one of R/I/S/B/U/L/J/JR/UPC, next state is FAULT; otherwise EXECUTE.
- EXECUTE: one cycle. Strobes (a,b,pass):
  - R=110, I=110, S=111, B=111, U=100, L=110, J=000, JR=100, UPC=000.
  - Next state is MEM for S or L, else LATCH.
- MEM:
  - Drives mem_req_o=1, mem_addr_o=alu_res_i, mem_wdata_o=store_data_i.
  - mem_we_o=1 for S only.
  - On ack: for L, load_data_o<=mem_rdata_i. Next state is LATCH.
- LATCH: wd_q_readin_o=1 for writer set W={R,I,U,L,UPC,J,JR}.
- WRITEBACK:
  - wd_q_o=1 for W; pc_readin_o=1 always; retired_o increments, wrapping at 2^CNT_W.
  - Next state is HALT if halt_i, else FETCH.
- HALT: all strobes 0. Leaves to FETCH in the cycle after halt_i is sampled low. halt_i in any other state is ignored until WRITEBACK.
- Timeout:
  - A wait counter clears on entry to FETCH/MEM and increments each cycle without ack.
  - If it reaches MAX_WAIT with no ack, next state is FAULT. An ack in the same cycle as the limit wins.
- FAULT: fault_o=1, all strobes and mem_req_o are 0. The state is sticky until reset.
- mem_ack_i outside FETCH/MEM is ignored.
- mem_addr_o/mem_wdata_o are 0 when mem_req_o=0.
- Latency with zero-wait memory: 5 cycles per non-memory instruction, 6 per load/store; each memory wait adds 1 cycle.

Decomposition:
- Package control_pkg:
  - itype codes (same values as itype.v).
  - State-code constants.
  - Functions is_writer(itype), is_mem(itype), operand_mask(itype).
- Sub-module wait_timer (parameter MAX_WAIT; inputs clear/ack; output expired).

Test Plan:
1. RTYPE, ack in the first FETCH cycle → stage sequence 1,2,3,5,6,1; readin a/b=1 in the EXECUTE cycle; wd_q_readin_o in LATCH; wd_q_o and pc_readin_o in WRITEBACK; retired_o 0→1.
2. LTYPE with mem_rdata_i=0xDEADBEEF and ack 3 cycles late in MEM → load_data_o=0xDEADBEEF; wd_q_o=1; 9 cycles FETCH-to-FETCH.
3. STYPE with alu_res_i=0x100 and store_data_i=0x55 → mem_we_o=1, mem_addr_o=0x100, mem_wdata_o=0x55 in MEM; wd_q_o stays 0.
4. MAX_WAIT=4, no ack in FETCH → FAULT after 4 cycles; fault_o=1 held; reset returns to IDLE with fault_o=0.
5. halt_i=1 during an ITYPE → WRITEBACK completes, then HALT(7); drop halt_i → FETCH the next cycle; an itype_i value outside the legal set goes to FAULT from DECODE.
6. Reset asserted mid-MEM with mem_req_o=1 → next cycle mem_req_o=0, all strobes 0, stage_o=0.
